// File: rtl/i2c_cfg_arbiter.sv
// i2c_cfg_arbiter: round-robin owner of the single i2c_com engine.
// Each grant issues one 24-bit {dev_addr, reg, data} write. A NACK is
// retried after a short idle gap. A watchdog aborts an attempt that never
// finishes. done/err pulse back to the requester that owned the grant.
//
// Handshake: a requester raises req[k] (level) with req_data slot k stable.
// gnt[k] rises when it is selected and stays high for the whole transfer.
// The transfer ends with exactly one done[k] or err[k] pulse, seen while
// gnt[k] is still high. A requester that keeps req[k] high after that gets
// no second write. It must drop req[k] for at least one cycle first.
module i2c_cfg_arbiter #(
    parameter int N_REQ   = 3,
    parameter int RETRY   = 2,
    parameter int TIMEOUT = 4095
) (
    input  logic                  clock_i2c,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [24*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      done,
    output logic [N_REQ-1:0]      err,
    output logic                  busy,
    output logic                  i2c_start,
    output logic [23:0]           i2c_data,
    input  logic                  tr_end,
    input  logic                  ack,
    output logic [2:0]            dbg_state
);

    localparam int PW = $clog2(N_REQ);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t           state;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    gidx;
    logic [2:0]       retry_cnt;
    logic [15:0]      tmo_cnt;
    logic [N_REQ-1:0] mask;

    logic [N_REQ-1:0] eligible;
    logic             pick_vld;
    logic [PW-1:0]    pick_idx;
    logic [PW:0]      cand;
    logic [23:0]      data_arr [N_REQ];

    assign dbg_state = state;

    // Split the packed request data bus into one word per requester.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            data_arr[i] = req_data[24*i +: 24];
        end
    end

    // Round-robin pick: the first eligible requester at or after rr_ptr.
    // The loop walks offsets from last to first so the smallest offset wins.
    always_comb begin
        eligible = req & ~mask;
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(N_REQ)) begin
                cand = cand - (PW+1)'(N_REQ);
            end
            if (eligible[cand[PW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[PW-1:0];
            end
        end
    end

    // Transaction FSM. All outputs are registered.
    // A mask bit is set when its requester is served. It clears once that
    // requester is seen low. This gives a held request exactly one write.
    always_ff @(posedge clock_i2c or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            gnt       <= '0;
            done      <= '0;
            err       <= '0;
            busy      <= 1'b0;
            i2c_start <= 1'b0;
            i2c_data  <= '0;
            rr_ptr    <= '0;
            gidx      <= '0;
            retry_cnt <= '0;
            tmo_cnt   <= '0;
            mask      <= '0;
        end else begin
            done <= '0;
            err  <= '0;
            mask <= mask & req;
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        gidx      <= pick_idx;
                        gnt       <= N_REQ'(1) << pick_idx;
                        i2c_data  <= data_arr[pick_idx];
                        retry_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    i2c_start <= 1'b1;
                    tmo_cnt   <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    // tr_end wins over the watchdog when both land together.
                    if (tr_end) begin
                        i2c_start <= 1'b0;
                        if (!ack) begin
                            done  <= gnt;
                            state <= S_FIN;
                        end else if (retry_cnt < 3'(RETRY)) begin
                            retry_cnt <= retry_cnt + 3'd1;
                            state     <= S_GAP;
                        end else begin
                            err   <= gnt;
                            state <= S_FIN;
                        end
                    end else if (tmo_cnt == 16'(TIMEOUT)) begin
                        i2c_start <= 1'b0;
                        err       <= gnt;
                        state     <= S_FIN;
                    end
                end
                S_GAP: begin
                    // i2c_start is low in this cycle and also in the START
                    // cycle. That gives i2c_com two idle cycles to re-arm.
                    state <= S_START;
                end
                S_FIN: begin
                    gnt    <= '0;
                    busy   <= 1'b0;
                    mask   <= (mask & req) | gnt;
                    rr_ptr <= (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
